sw_event: RTL and testbench

SW_EVENT -- requirements
Module: sw_event

---
 rtl/sw_event_if.sv | 11 +
 rtl/sw_event.sv | 175 +++++++++++++++++
 tb/tb_sw_event.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sw_event_if.sv
// Button bus for sw_event: raw active-low switches in; debounced levels,
// one-cycle press events and the sample tick strobe out.
interface sw_event_if;
  logic [2:0] i_sw;
  logic [2:0] o_press;
  logic [2:0] o_level;
  logic       o_tick;

  modport master (output i_sw, input o_press, o_level, o_tick);
  modport slave  (input i_sw, output o_press, o_level, o_tick);
endinterface

// File: rtl/sw_event.sv
// Three-button debouncer with per-button press event FSM.
// Define SW_EVENT_AUTO_REPEAT_EN to build the REPEAT state and its per-button tick counter.
module sw_event #(
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned DB_CNT   = 2,
  parameter int unsigned REP_DLY  = 50,
  parameter int unsigned REP_PER  = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  sw_event_if.slave bus
);

  localparam int unsigned  TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [3:0]   DB_LIM   = 4'(DB_CNT);

`ifdef SW_EVENT_AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  localparam logic [7:0] DLY_LIM = 8'(REP_DLY);
  localparam logic [7:0] PER_LIM = 8'(REP_PER);
  logic [2:0][7:0] rcnt, rcnt_nxt;
`else
  typedef enum logic {IDLE, HOLD} state_t;
`endif

  logic [2:0]      sync1, sync2, pressed;
  logic [TW-1:0]   tcnt;
  logic            tick;
  logic [2:0][3:0] agree, agree_nxt;
  logic [2:0]      level, level_nxt, level_d, rise;
  logic [2:0]      press_q, press_set;
  state_t          state     [3];
  state_t          state_nxt [3];

  function automatic logic [3:0] sat4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

`ifdef SW_EVENT_AUTO_REPEAT_EN
  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= bus.i_sw;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  assign tick = rst_n && (tcnt == TICK_MAX);

  always_comb begin
    agree_nxt = agree;
    level_nxt = level;
    if (tick) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (pressed[i] != level[i]) begin
          if (sat4(agree[i]) >= DB_LIM) begin
            agree_nxt[i] = '0;
            level_nxt[i] = ~level[i];
          end else begin
            agree_nxt[i] = sat4(agree[i]);
          end
        end else begin
          agree_nxt[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      agree   <= '0;
      level   <= '0;
      level_d <= '0;
    end else begin
      agree   <= agree_nxt;
      level   <= level_nxt;
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 3; i++) state[i] <= IDLE;
      press_q <= '0;
`ifdef SW_EVENT_AUTO_REPEAT_EN
      rcnt    <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < 3; i++) state[i] <= state_nxt[i];
      press_q <= press_set & ~press_q;
`ifdef SW_EVENT_AUTO_REPEAT_EN
      rcnt    <= rcnt_nxt;
`endif
    end
  end

  // A repeat is only honoured while the debouncer is not dropping the level on this same tick.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        IDLE: if (rise[i]) state_nxt[i] = HOLD;
        HOLD: begin
          if (!level[i]) state_nxt[i] = IDLE;
`ifdef SW_EVENT_AUTO_REPEAT_EN
          else if (tick && level_nxt[i] && sat8(rcnt[i]) >= DLY_LIM) state_nxt[i] = REPEAT;
`endif
        end
`ifdef SW_EVENT_AUTO_REPEAT_EN
        REPEAT: if (!level[i]) state_nxt[i] = IDLE;
`endif
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    press_set = '0;
`ifdef SW_EVENT_AUTO_REPEAT_EN
    rcnt_nxt  = rcnt;
`endif
    for (int unsigned i = 0; i < 3; i++) begin
      case (state[i])
        IDLE: if (rise[i]) begin
          press_set[i] = 1'b1;
`ifdef SW_EVENT_AUTO_REPEAT_EN
          rcnt_nxt[i]  = '0;
`endif
        end
`ifdef SW_EVENT_AUTO_REPEAT_EN
        HOLD: if (tick && level[i] && level_nxt[i]) begin
          if (sat8(rcnt[i]) >= DLY_LIM) begin
            press_set[i] = 1'b1;
            rcnt_nxt[i]  = '0;
          end else begin
            rcnt_nxt[i]  = sat8(rcnt[i]);
          end
        end
        REPEAT: if (tick && level[i] && level_nxt[i]) begin
          if (sat8(rcnt[i]) >= PER_LIM) begin
            press_set[i] = 1'b1;
            rcnt_nxt[i]  = '0;
          end else begin
            rcnt_nxt[i]  = sat8(rcnt[i]);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.o_press = press_q;
  assign bus.o_level = level;
  assign bus.o_tick  = tick;

endmodule

// File: tb/tb_sw_event.sv
// Scoreboard bench for sw_event: expected press cycles and level windows are
// computed from the tick grid when stimulus is applied, then matched per cycle.
module tb_sw_event;

  localparam int T     = 4;
  localparam int DB    = 2;
  localparam int RD    = 3;
  localparam int RP    = 2;
  localparam int NEVER = 1 << 30;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sw_event_if bus ();

  sw_event #(
    .TICK_DIV (T),
    .DB_CNT   (DB),
    .REP_DLY  (RD),
    .REP_PER  (RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         cyc;
  int         n_chk = 0;
  int         n_err = 0;
  int         exp_q [3][$];
  int         lv_on [3];
  int         lv_off[3];
  logic [2:0] prev;
  bit         exp_now;
  int         n;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // First consumed tick edge at or after posedge x.
  function automatic int tick_ge(input int x);
    return ((x + T - 1) / T) * T;
  endfunction

  // Edge at which the debounced level drops for a release driven after edge r.
  function automatic int cut_of(input int r);
    return tick_ge(r + 3) + (DB - 1) * T;
  endfunction

  task automatic sched(input int b, input int start, input int cut);
    int p2;
    int t;
    p2 = tick_ge(start + 3) + (DB - 1) * T;
    lv_on[b]  = p2;
    lv_off[b] = cut;
    if (p2 < cut) exp_q[b].push_back(p2 + 1);
`ifdef SW_EVENT_AUTO_REPEAT_EN
    t = p2 + RD * T;
    while (t < cut) begin
      exp_q[b].push_back(t);
      t += RP * T;
    end
`else
    t = p2;
`endif
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
    #2;
  endtask

  task automatic wait_until(input int c);
    int g = 0;
    while (cyc < c && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("wait_cycle", cyc, c);
    #2;
  endtask

  task automatic pending();
    for (int b = 0; b < 3; b++) check($sformatf("pending%0d", b), exp_q[b].size(), 0);
  endtask

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_press", int'(bus.o_press), 0);
      check("rst_level", int'(bus.o_level), 0);
      check("rst_tick",  int'(bus.o_tick), 0);
      prev = '0;
    end else begin
      check("tick", int'(bus.o_tick), int'(cyc % T == T - 1));
      for (int b = 0; b < 3; b++) begin
        check($sformatf("level%0d", b), int'(bus.o_level[b]),
              int'(cyc >= lv_on[b] && cyc < lv_off[b]));
        exp_now = (exp_q[b].size() > 0) && (exp_q[b][0] == cyc);
        if (bus.o_press[b] || exp_now) begin
          check($sformatf("press%0d", b), int'(bus.o_press[b]), int'(exp_now));
          if (exp_now) void'(exp_q[b].pop_front());
        end
        if (bus.o_press[b]) check($sformatf("no_double%0d", b), int'(prev[b]), 0);
      end
      prev = bus.o_press;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000 ns");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int b = 0; b < 3; b++) begin
      lv_on[b]  = NEVER;
      lv_off[b] = 0;
    end
    prev       = '0;
    bus.i_sw   = 3'b111;
    rst_n      = 1'b0;
    step(5);
    rst_n = 1'b1;

    // idle: ticks only
    step(100);

    // single press on bit 0
    n = cyc;
    sched(0, n, cut_of(n + 40));
    bus.i_sw[0] = 1'b0;
    step(40);
    bus.i_sw[0] = 1'b1;
    step(30);
    pending();

    // one-tick glitch on bit 1
    bus.i_sw[1] = 1'b0;
    step(4);
    bus.i_sw[1] = 1'b1;
    step(30);
    pending();

    // long hold on bit 2 (12 ticks)
    n = cyc;
    sched(2, n, cut_of(n + 12 * T));
    bus.i_sw[2] = 1'b0;
    step(12 * T);
    bus.i_sw[2] = 1'b1;
    step(30);
    pending();

    // simultaneous press of bits 0 and 1
    n = cyc;
    sched(0, n, cut_of(n + 20));
    sched(1, n, cut_of(n + 20));
    bus.i_sw = 3'b100;
    step(20);
    bus.i_sw = 3'b111;
    step(30);
    pending();

    // reset pulsed while bit 0 is held past the repeat delay
    n = cyc;
    sched(0, n, n + 41);
    bus.i_sw[0] = 1'b0;
    step(40);
    rst_n = 1'b0;
    #1;
    check("async_rst_level", int'(bus.o_level), 0);
    check("async_rst_press", int'(bus.o_press), 0);
    check("async_rst_tick",  int'(bus.o_tick), 0);
    pending();
    for (int b = 0; b < 3; b++) begin
      lv_on[b]  = NEVER;
      lv_off[b] = 0;
    end
    step(3);
    rst_n = 1'b1;
    sched(0, 0, cut_of(9));
    wait_until(9);
    bus.i_sw[0] = 1'b1;
    step(30);
    pending();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
